// File: rtl/miner_host_pkg.sv
// rtl/miner_host_pkg.sv - state encoding and miner CSR map shared by miner_host_master
package miner_host_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LD_TGT,
      ST_LD_MSG,
      ST_CTRL_CLR,
      ST_CTRL_SET,
      ST_POLL_WAIT,
      ST_POLL_RD,
      ST_POLL_CHK,
      ST_NONCE_RD,
      ST_NONCE_CHK,
      ST_REPORT,
      ST_ABORT_CLR
   } state_t;

   localparam logic [4:0] ADDR_CTRL        = 5'd0;
   localparam logic [4:0] ADDR_STATUS      = 5'd1;
   localparam logic [4:0] ADDR_NONCE       = 5'd2;
   localparam logic [4:0] ADDR_TARGET_BASE = 5'd8;
   localparam logic [4:0] ADDR_MSG_BASE    = 5'd16;

   localparam logic [4:0] TGT_LAST_IDX = 5'd7;
   localparam logic [4:0] MSG_LAST_IDX = 5'd15;

   localparam int STAT_FOUND     = 1;
   localparam int STAT_EXHAUSTED = 2;

   // newTarget | newMsg
   localparam logic [31:0] CTRL_START = 32'h3;
   localparam logic [31:0] CTRL_CLEAR = 32'h0;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/miner_read_pipe.sv
// rtl/miner_read_pipe.sv - tracks one outstanding CSR read and flags when its data is valid
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   issue_i      a read strobe is on the bus this cycle
//   flush_i      forget any read still in flight
//   rd_data_i    bus read data
//   rd_done_o    read data for the issued read is valid this cycle
//   rd_data_o    that read data (0 when rd_done_o is low)
module miner_read_pipe #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        issue_i,
   input  logic        flush_i,
   input  logic [31:0] rd_data_i,
   output logic        rd_done_o,
   output logic [31:0] rd_data_o
);

   logic [READ_LATENCY-1:0] pend_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pend_q <= '0;
      end else if (flush_i) begin
         pend_q <= '0;
      end else begin
         pend_q[0] <= issue_i;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pend_q[i] <= pend_q[i-1];
         end
      end
   end

   // Last stage is set exactly READ_LATENCY cycles after the read cycle,
   // which is the cycle the slave drives valid data.
   assign rd_done_o = pend_q[READ_LATENCY-1];
   assign rd_data_o = rd_done_o ? rd_data_i : '0;

endmodule

// File: rtl/miner_host_master.sv
// rtl/miner_host_master.sv - Avalon-MM host master that loads, starts and polls the miner
// Ports:
//   clk, n_rst                    clock, asynchronous active-low reset
//   in_valid/in_data/in_ready     job word stream: 8 target words then 16 message words
//   abort                         cancel the job in progress
//   m_chipselect/m_write/m_read   Avalon-MM strobes toward the miner CSR slave
//   m_addr/m_writedata/m_readdata Avalon-MM address and data
//   res_valid/res_ready           result record handshake
//   res_found/res_nonce/res_error result fields, valid while res_valid
module miner_host_master #(
   parameter int          READ_LATENCY = 1,
   parameter int          POLL_GAP     = 4,
   parameter logic [15:0] POLL_LIMIT   = 16'hFFFF
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   input  logic        abort,
   output logic        m_chipselect,
   output logic        m_write,
   output logic        m_read,
   output logic [4:0]  m_addr,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        res_found,
   output logic [31:0] res_nonce,
   output logic        res_error
);

   import miner_host_pkg::*;

   localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [15:0] gap_q, gap_d;
   logic [15:0] poll_q, poll_d;
   logic        found_q, found_d;
   logic        error_q, error_d;
   logic [31:0] nonce_q, nonce_d;
   logic        alive_q;

   logic        issue_rd;
   logic        flush_rd;
   logic        rd_done;
   logic [31:0] rd_data;

   miner_read_pipe #(
      .READ_LATENCY (READ_LATENCY)
   ) u_read_pipe (
      .clk       (clk),
      .n_rst     (n_rst),
      .issue_i   (issue_rd),
      .flush_i   (flush_rd),
      .rd_data_i (m_readdata),
      .rd_done_o (rd_done),
      .rd_data_o (rd_data)
   );

   // Holds in_ready low until the first clock after reset release, so the
   // combinational IDLE write path stays quiet while n_rst is asserted.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         alive_q <= 1'b0;
      end else begin
         alive_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         gap_q   <= '0;
         poll_q  <= '0;
         found_q <= 1'b0;
         error_q <= 1'b0;
         nonce_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         poll_q  <= poll_d;
         found_q <= found_d;
         error_q <= error_d;
         nonce_q <= nonce_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      gap_d       = gap_q;
      poll_d      = poll_q;
      found_d     = found_q;
      error_d     = error_q;
      nonce_d     = nonce_q;
      in_ready    = 1'b0;
      m_write     = 1'b0;
      m_read      = 1'b0;
      m_addr      = '0;
      m_writedata = '0;
      issue_rd    = 1'b0;
      flush_rd    = 1'b0;
      res_valid   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = alive_q;
            if (in_valid && alive_q) begin
               m_write     = 1'b1;
               m_addr      = ADDR_TARGET_BASE;
               m_writedata = in_data;
               idx_d       = 5'd1;
               state_d     = ST_LD_TGT;
            end
         end
         ST_LD_TGT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               m_write     = 1'b1;
               m_addr      = ADDR_TARGET_BASE + idx_q;
               m_writedata = in_data;
               if (idx_q == TGT_LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_LD_MSG;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         ST_LD_MSG: begin
            in_ready = 1'b1;
            if (in_valid) begin
               m_write     = 1'b1;
               m_addr      = ADDR_MSG_BASE + idx_q;
               m_writedata = in_data;
               if (idx_q == MSG_LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_CTRL_CLR;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         // Clearing CTRL first guarantees the miner sees a rising edge on
         // newTarget and newMsg even if a previous job left them set.
         ST_CTRL_CLR: begin
            m_write     = 1'b1;
            m_addr      = ADDR_CTRL;
            m_writedata = CTRL_CLEAR;
            state_d     = ST_CTRL_SET;
         end
         ST_CTRL_SET: begin
            m_write     = 1'b1;
            m_addr      = ADDR_CTRL;
            m_writedata = CTRL_START;
            poll_d      = '0;
            gap_d       = '0;
            found_d     = 1'b0;
            error_d     = 1'b0;
            nonce_d     = '0;
            state_d     = ST_POLL_WAIT;
         end
         ST_POLL_WAIT: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = ST_POLL_RD;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         ST_POLL_RD: begin
            m_read   = 1'b1;
            m_addr   = ADDR_STATUS;
            issue_rd = 1'b1;
            poll_d   = sat_inc16(poll_q);
            state_d  = ST_POLL_CHK;
         end
         ST_POLL_CHK: begin
            if (rd_done) begin
               if (rd_data[STAT_FOUND]) begin
                  state_d = ST_NONCE_RD;
               end else if (rd_data[STAT_EXHAUSTED]) begin
                  error_d = 1'b1;
                  state_d = ST_REPORT;
               end else if (poll_q >= POLL_LIMIT) begin
                  error_d = 1'b1;
                  state_d = ST_REPORT;
               end else begin
                  state_d = ST_POLL_WAIT;
               end
            end
         end
         ST_NONCE_RD: begin
            m_read   = 1'b1;
            m_addr   = ADDR_NONCE;
            issue_rd = 1'b1;
            state_d  = ST_NONCE_CHK;
         end
         ST_NONCE_CHK: begin
            if (rd_done) begin
               nonce_d = rd_data;
               found_d = 1'b1;
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_ABORT_CLR: begin
            m_write     = 1'b1;
            m_addr      = ADDR_CTRL;
            m_writedata = CTRL_CLEAR;
            flush_rd    = 1'b1;
            idx_d       = '0;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The bus access chosen above still happens this cycle; abort only
      // redirects where the machine goes next.
      if (abort && (state_q != ST_IDLE) && (state_q != ST_REPORT)
                && (state_q != ST_ABORT_CLR)) begin
         state_d = ST_ABORT_CLR;
      end
   end

   assign m_chipselect = m_read | m_write;
   assign res_found    = (state_q == ST_REPORT) & found_q;
   assign res_error    = (state_q == ST_REPORT) & error_q;
   assign res_nonce    = (state_q == ST_REPORT) ? nonce_q : '0;

endmodule

// File: tb/tb_miner_host_master.sv
// tb/tb_miner_host_master.sv - scoreboard bench for miner_host_master
`timescale 1ns/1ps
module tb_miner_host_master;

   localparam int          RL  = 2;
   localparam int          GAP = 4;
   localparam logic [15:0] LIM = 16'd3;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic        abort = 1'b0;
   logic        m_chipselect, m_write, m_read;
   logic [4:0]  m_addr;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        res_found;
   logic [31:0] res_nonce;
   logic        res_error;

   always #5 clk = ~clk;

   miner_host_master #(
      .READ_LATENCY (RL),
      .POLL_GAP     (GAP),
      .POLL_LIMIT   (LIM)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .abort        (abort),
      .m_chipselect (m_chipselect),
      .m_write      (m_write),
      .m_read       (m_read),
      .m_addr       (m_addr),
      .m_writedata  (m_writedata),
      .m_readdata   (m_readdata),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_found    (res_found),
      .res_nonce    (res_nonce),
      .res_error    (res_error)
   );

   typedef struct {
      bit        wr;
      bit [4:0]  addr;
      bit [31:0] data;
   } bus_op_t;

   typedef struct {
      bit        found;
      bit [31:0] nonce;
      bit        err;
   } res_t;

   bus_op_t     exp_bus[$];
   res_t        exp_res[$];
   logic [31:0] status_script[$];
   logic [31:0] status_dflt = '0;
   logic [31:0] nonce_val = '0;
   logic [31:0] rd_stage [RL];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_span = 23;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slave model: read issued in cycle r drives m_readdata during cycle r+RL.
   initial for (int k = 0; k < RL; k++) rd_stage[k] = '0;
   always @(negedge clk) begin
      m_readdata = rd_stage[RL-1];
      for (int k = RL - 1; k > 0; k--) rd_stage[k] = rd_stage[k-1];
      rd_stage[0] = '0;
      if (m_read) begin
         if (m_addr == 5'd1) begin
            if (status_script.size() > 0) rd_stage[0] = status_script.pop_front();
            else rd_stage[0] = status_dflt;
         end else if (m_addr == 5'd2) begin
            rd_stage[0] = nonce_val;
         end
      end
   end

   // Monitor: pops expected bus ops and results as the DUT presents them.
   int          set_cyc = 0, last_stat = 0, load_start = 0;
   bit          first_poll = 0, nonce_seen = 0, res_seen = 0;
   logic [33:0] held = '0;
   always @(negedge clk) begin
      bus_op_t op;
      res_t    r;
      if (n_rst) begin
         check("chipselect", m_chipselect, m_read | m_write);
         check("rd_wr_excl", m_read & m_write, 0);
         if (m_read || m_write) begin
            if (exp_bus.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_bus: wr=%0b addr=%0d data=%h with none expected", m_write, m_addr, m_writedata);
            end else begin
               op = exp_bus.pop_front();
               check("bus_dir", m_write, op.wr);
               check("bus_addr", m_addr, op.addr);
               if (op.wr) check("bus_wdata", m_writedata, op.data);
            end
            if (m_write && m_addr == 5'd8) load_start = cyc;
            if (m_write && m_addr == 5'd31) check("load_span", cyc - load_start, exp_span);
            if (m_write && m_addr == 5'd0 && m_writedata == 32'h3) begin
               set_cyc = cyc;
               first_poll = 1;
               nonce_seen = 0;
            end
            if (m_read && m_addr == 5'd1) begin
               if (first_poll) begin
                  check("start_to_poll", cyc - set_cyc, GAP + 1);
                  first_poll = 0;
               end
               last_stat = cyc;
            end
            if (m_read && m_addr == 5'd2) nonce_seen = 1;
         end
         if (res_valid) begin
            if (!res_seen) begin
               res_seen = 1;
               held = {res_found, res_nonce, res_error};
               check("res_latency", cyc - last_stat, nonce_seen ? 2 * RL + 2 : RL + 1);
               if (exp_res.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_result: found=%0b nonce=%h err=%0b", res_found, res_nonce, res_error);
               end else begin
                  r = exp_res.pop_front();
                  check("res_found", res_found, r.found);
                  check("res_nonce", res_nonce, r.nonce);
                  check("res_error", res_error, r.err);
               end
            end else begin
               check("res_stable", {res_found, res_nonce, res_error}, held);
            end
            if (res_ready) res_seen = 0;
         end else begin
            check("res_idle_zero", {res_found, res_nonce, res_error}, 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_op(input bit wr, input bit [4:0] addr, input bit [31:0] data);
      bus_op_t op;
      op.wr = wr;
      op.addr = addr;
      op.data = data;
      exp_bus.push_back(op);
   endtask

   task automatic push_res(input bit found, input bit [31:0] nonce, input bit err);
      res_t r;
      r.found = found;
      r.nonce = nonce;
      r.err = err;
      exp_res.push_back(r);
   endtask

   task automatic send_word(input logic [31:0] d);
      int t = 0;
      in_valid = 1'b1;
      in_data = d;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 100);
      check("in_ready_wait", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic run_load(input logic [31:0] base, input bit gapped);
      for (int i = 0; i < 24; i++) push_op(1, 5'(8 + i), base + 32'(i));
      push_op(1, 5'd0, 32'h0);
      push_op(1, 5'd0, 32'h3);
      exp_span = gapped ? 46 : 23;
      for (int i = 0; i < 24; i++) begin
         send_word(base + 32'(i));
         if (gapped) tick();
      end
   endtask

   task automatic wait_result(input int hold);
      int t = 0;
      while (!res_valid && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("res_valid_wait", res_valid, 1);
      repeat (hold) tick();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      @(negedge clk);
      check("res_valid_drop", res_valid, 0);
      tick();
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      // Reset: in_valid held high to show nothing leaks onto the bus.
      in_valid = 1'b1;
      in_data = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_chipselect", m_chipselect, 0);
      check("rst_write", m_write, 0);
      check("rst_res_valid", res_valid, 0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      @(negedge clk);
      check("in_ready_before_edge", in_ready, 0);
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1);
      tick();

      // Job 1: continuous stream, two empty polls then found.
      status_script = '{32'h0, 32'h0, 32'h3};
      nonce_val = 32'hDEADBEEF;
      run_load(32'h100, 0);
      push_op(0, 5'd1, 0);
      push_op(0, 5'd1, 0);
      push_op(0, 5'd1, 0);
      push_op(0, 5'd2, 0);
      push_res(1, 32'hDEADBEEF, 0);
      wait_result(5);

      // Job 2: gapped stream, complete+exhausted on first poll.
      status_script = '{32'h5};
      run_load(32'h200, 1);
      push_op(0, 5'd1, 0);
      push_res(0, 32'h0, 1);
      wait_result(0);

      // Job 3: status never completes; POLL_LIMIT=3 reads then timeout.
      status_script = {};
      status_dflt = 32'h0;
      run_load(32'h300, 0);
      push_op(0, 5'd1, 0);
      push_op(0, 5'd1, 0);
      push_op(0, 5'd1, 0);
      push_res(0, 32'h0, 1);
      wait_result(1);

      // Job 4: abort after target word 4.
      for (int i = 0; i < 5; i++) push_op(1, 5'(8 + i), 32'h400 + 32'(i));
      push_op(1, 5'd0, 32'h0);
      for (int i = 0; i < 5; i++) send_word(32'h400 + 32'(i));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      repeat (20) tick();
      check("abort_no_result", res_valid, 0);
      check("abort_bus_drained", exp_bus.size(), 0);
      check("abort_in_ready", in_ready, 1);

      // Job 5: full job after abort completes normally.
      status_script = '{32'h3};
      nonce_val = 32'h12345678;
      run_load(32'h500, 0);
      push_op(0, 5'd1, 0);
      push_op(0, 5'd2, 0);
      push_res(1, 32'h12345678, 0);
      wait_result(0);

      repeat (5) tick();
      check("bus_queue_empty", exp_bus.size(), 0);
      check("res_queue_empty", exp_res.size(), 0);
      check("script_consumed", status_script.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/miner_host_master.md
# miner_host_master

Avalon-MM master that drives the miner's CSR slave from the host side. It accepts a mining job as a word stream (8 target words, then 16 message words), writes them into the miner's register map, and pulses the control register to start a search. It then polls the status register until completion, fetches the nonce on a hit, and returns a single result record. It sits between the job-dispatch logic and the miner's slave port, replacing software register programming.

## Interface
Parameters:
- READ_LATENCY, 1, cycles from read-accept to m_readdata valid (1..3)
- POLL_GAP, 4, idle cycles between consecutive status reads (≥1)
- POLL_LIMIT, 16'hFFFF, status reads before timeout error

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  job word valid
- in_data  in  32  job word (targets 0..7, then message 0..15)
- in_ready  out  1  job word accepted when in_valid & in_ready
- abort  in  1  cancel current job
- m_chipselect  out  1  bus cycle active
- m_write  out  1  write strobe
- m_read  out  1  read strobe
- m_addr  out  5  word address
- m_writedata  out  32  write data
- m_readdata  in  32  read data
- res_valid  out  1  result held until res_ready
- res_ready  in  1  result consumed
- res_found  out  1  nonce meeting target found
- res_nonce  out  32  found nonce (0 if !res_found)
- res_error  out  1  poll timeout or nonce exhaustion

## Operation
- Register map: CTRL=0 (bit0 newTarget, bit1 newMsg), STATUS=1 (bit0 complete, bit1 found, bit2 exhausted), NONCE=2, TARGET_BASE=8 (8..15), MSG_BASE=16 (16..31).
- States: IDLE, LD_TGT, LD_MSG, CTRL_CLR, CTRL_SET, POLL_WAIT, POLL_RD, POLL_CHK, NONCE_RD, REPORT.
- IDLE: in_ready=1 once res_valid is clear; first accepted word → LD_TGT with it written.
- LD_TGT/LD_MSG: in_ready=1; each accepted word is written the same cycle (m_chipselect=m_write=1, m_addr=base+idx, m_writedata=in_data). 5-bit idx counts 0..7 then 0..15; after target word 7 → LD_MSG, after message word 15 → CTRL_CLR. No bus activity when in_valid=0.
- CTRL_CLR: write 0 to CTRL (1 cycle). CTRL_SET: write 32'h3 to CTRL (1 cycle), clear poll counter → POLL_WAIT. CLR before SET guarantees a rising edge on both bits.
- POLL_WAIT: count POLL_GAP cycles → POLL_RD. POLL_RD: one-cycle read of STATUS, increment poll counter. POLL_CHK: wait READ_LATENCY cycles, sample m_readdata.
- Sampled status: found → NONCE_RD; exhausted & !found → REPORT with res_error=1; else if poll counter == POLL_LIMIT → REPORT with res_error=1; else → POLL_WAIT.
- NONCE_RD: one-cycle read of NONCE, sample after READ_LATENCY into res_nonce → REPORT with res_found=1.
- REPORT: res_valid=1, fields stable until res_valid & res_ready → IDLE (next job accepted the following cycle).
- abort (any state except IDLE/REPORT): the current-cycle bus access completes; next cycle write 0 to CTRL, then IDLE; no result produced, partially loaded words discarded. abort in IDLE/REPORT is ignored.
- Never assert m_read and m_write together; m_chipselect = m_read | m_write.

## Timing
- Reset: all outputs 0, state IDLE, counters 0; in_ready rises first cycle after n_rst deassertion.
- Reset mid-operation: bus strobes drop asynchronously; miner is not cleared by this block.
- Load: minimum 24 cycles (one word/cycle at full in_valid), then 2 control-write cycles.
- Start-to-first-status-sample: POLL_GAP + 1 + READ_LATENCY cycles after CTRL_SET.
- Hit: NONCE result at res_valid 1 + READ_LATENCY + 1 cycles after found sampled.
- Poll counter is 16 bits, saturating; POLL_LIMIT=0 means timeout after first non-complete status.
- abort and final in_valid word in same cycle: word written, then abort path taken.

## Structure
- Package miner_host_pkg: state enum, CTRL/STATUS/NONCE/TARGET_BASE/MSG_BASE constants, status bit indices, control value 32'h3.
- Sub-module miner_read_pipe: issues one read, delays by READ_LATENCY, emits rd_done with captured data; used for STATUS and NONCE.

## Test plan
- Continuous 24-word stream 32'h100..32'h117 → writes addr 8..15 data 100..107, addr 16..31 data 108..117, then CTRL=0, CTRL=3.
- Stream with in_valid low every other cycle → identical write sequence, no writes on idle cycles, 48-cycle load.
- Status model returns 0 twice then 32'h3, NONCE=32'hDEADBEEF → res_valid with res_found=1, res_nonce=DEADBEEF, res_error=0; held while res_ready=0 for 5 cycles.
- Status returns 32'h5 (complete+exhausted) → res_found=0, res_nonce=0, res_error=1.
- POLL_LIMIT=3, status always 0 → exactly 3 STATUS reads, then res_error=1.
- abort after target word 4 → one CTRL=0 write, IDLE, no res_valid; following full job completes normally.
